mips_inst_encoder: RTL

Sequential MIPS instruction encoder: the inverse of the single-cycle control unit's op/func decode. It accepts symbolic instructions (mnemonic code plus register, shift, immediate and target fields) over a valid/ready handshake. It packs each one into a 32-bit MIPS word and writes it into the instruction-memory write port at an auto-incrementing address. It sits between the test/boot loader and instruction memory, and supports exactly the instruction set the single-cycle CPU decodes.

---
 rtl/mips_inst_encoder_if.sv | 23 ++
 rtl/mips_inst_encoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mips_inst_encoder_if.sv
// Symbolic instruction beat bus between the loader (master) and the encoder (slave).
interface mips_inst_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_mnem;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_sa;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;

   modport master (
      output in_valid, in_mnem, in_rs, in_rt, in_rd, in_sa, in_imm, in_target, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_sa, in_imm, in_target, in_last,
      output in_ready
   );
endinterface

// File: rtl/mips_inst_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and streams them into the
// instruction-memory write port at an auto-incrementing, wrapping address.
module mips_inst_encoder #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DEPTH  = 64
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   mips_inst_encoder_if.slave  bus,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [31:0]         imem_wdata,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W:0]     count
);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   logic              state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic              err_q;
   logic              done_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_wdata_q;

   logic              legal;
   logic [31:0]       word;
   logic              accept;
   logic [ADDR_W:0]   count_nxt;
   logic              hit_depth;
   logic              finish;
   logic              overflow;

   always_comb begin
      legal = 1'b1;
      word  = 32'h0;
      unique case (bus.in_mnem)
         5'd0:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
         5'd1:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
         5'd2:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24};
         5'd3:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25};
         5'd4:  word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h26};
         5'd5:  word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'h00};
         5'd6:  word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'h02};
         5'd7:  word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_sa, 6'h03};
         5'd8:  word = {6'h00, bus.in_rs, 15'd0, 6'h08};
         5'd9:  word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd10: word = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd11: word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd12: word = {6'h0E, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd13: word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd14: word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd15: word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd16: word = {6'h05, bus.in_rs, bus.in_rt, bus.in_imm};
         5'd17: word = {6'h0F, 5'd0, bus.in_rt, bus.in_imm};
         5'd18: word = {6'h02, bus.in_target};
         5'd19: word = {6'h03, bus.in_target};
         default: legal = 1'b0;
      endcase
   end

   assign accept    = bus.in_valid && (state_q == RUN);
   assign count_nxt = count_q + (ADDR_W + 1)'(1);
   assign hit_depth = legal && (count_nxt == DEPTH_CNT);
   assign finish    = accept && (bus.in_last || hit_depth);
   // in_last on the DEPTH-th word is a clean end, not an overflow.
   assign overflow  = accept && hit_depth && !bus.in_last;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'h0;
      end else begin
         imem_we_q <= 1'b0;
         done_q    <= 1'b0;
         if (state_q == IDLE) begin
            if (start) begin
               addr_q  <= base_addr;
               count_q <= '0;
               err_q   <= 1'b0;
               state_q <= RUN;
            end
         end else if (accept) begin
            if (legal) begin
               imem_we_q    <= 1'b1;
               imem_addr_q  <= addr_q;
               imem_wdata_q <= word;
               addr_q       <= addr_q + ADDR_W'(1);
               count_q      <= count_nxt;
            end else begin
               err_q <= 1'b1;
            end
            if (overflow) err_q <= 1'b1;
            if (finish) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready = (state_q == RUN);
   assign busy         = (state_q == RUN);
   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign done         = done_q;
   assign err          = err_q;
   assign count        = count_q;

endmodule
